// File: rtl/wd_bus_sequencer.sv
// Sole bus master for the watchdog ABUS/DBUS port: arbitrates the config and
// command requesters and plays the AA/55 unlock followed by the four write slots.
module wd_bus_sequencer #(
    parameter int unsigned UNLOCK_GAP = 0,
    parameter int unsigned IDLE_MIN   = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cfg_req,
    input  logic [7:0] cfg_frame,
    input  logic [7:0] cfg_service,
    input  logic [7:0] cfg_limit,
    input  logic       cmd_req,
    input  logic [7:0] cmd_data,
    input  logic       wd_fail,
    output logic [1:0] ABUS,
    output logic [7:0] DBUS,
    output logic       busy,
    output logic       cfg_ack,
    output logic       cmd_ack,
    output logic       cmd_nak
);

    typedef enum logic [3:0] {
        S_IDLE, S_UNL_A, S_GAP, S_UNL_B, S_WR1, S_WR2, S_WR3, S_WR4, S_HOLD
    } state_t;

    localparam logic [3:0] GAP_LOAD   = 4'(UNLOCK_GAP);
    // The arbitrating IDLE cycle is part of the post-burst gap, so HOLD covers
    // IDLE_MIN-1 cycles after a burst; after a nak the requester still needs a
    // full IDLE_MIN of non-arbitrating cycles to drop its request.
    localparam logic [3:0] HOLD_BURST = 4'(IDLE_MIN - 1);
    localparam logic [3:0] HOLD_NAK   = 4'(IDLE_MIN);

    state_t     state_q, state_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       fail_lock_q, fail_lock_d;
    logic       nak_q, nak_d;
    logic [1:0] abus_q, abus_d;
    logic [7:0] dbus_q, dbus_d;
    logic       is_cfg_q;
    logic [7:0] frame_q, service_q, limit_q, cmd_q;
    logic       grant_cfg, grant_cmd;

    always_ff @(posedge CLK) begin
        // NOTE: every register here uses <= so all of them see the pre-edge values.
        if (RST) begin
            state_q     <= S_IDLE;
            gap_cnt_q   <= 4'd0;
            hold_cnt_q  <= 4'd0;
            fail_lock_q <= 1'b0;
            nak_q       <= 1'b0;
            abus_q      <= 2'b10;
            dbus_q      <= 8'h00;
            // NOTE: the burst payload registers are reset too; they are only a
            // handful of flops and this keeps the post-reset state fully defined.
            is_cfg_q    <= 1'b0;
            frame_q     <= 8'h00;
            service_q   <= 8'h00;
            limit_q     <= 8'h00;
            cmd_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            fail_lock_q <= fail_lock_d;
            nak_q       <= nak_d;
            abus_q      <= abus_d;
            dbus_q      <= dbus_d;
            if (grant_cfg) begin
                is_cfg_q  <= 1'b1;
                frame_q   <= cfg_frame;
                service_q <= cfg_service;
                limit_q   <= cfg_limit;
            end else if (grant_cmd) begin
                is_cfg_q <= 1'b0;
                cmd_q    <= cmd_data;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case can infer a latch.
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        hold_cnt_d = hold_cnt_q;
        grant_cfg  = 1'b0;
        grant_cmd  = 1'b0;
        nak_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_req) begin
                    grant_cfg = 1'b1;
                    state_d   = S_UNL_A;
                end else if (cmd_req && !fail_lock_q) begin
                    grant_cmd = 1'b1;
                    state_d   = S_UNL_A;
                end else if (cmd_req) begin
                    nak_d      = 1'b1;
                    state_d    = S_HOLD;
                    hold_cnt_d = HOLD_NAK;
                end
            end
            S_UNL_A: begin
                if (GAP_LOAD != 4'd0) begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = S_UNL_B;
                end
            end
            S_GAP: begin
                if (gap_cnt_q <= 4'd1) state_d = S_UNL_B;
                else                   gap_cnt_d = gap_cnt_q - 4'd1;
            end
            S_UNL_B: state_d = S_WR1;
            S_WR1:   state_d = S_WR2;
            S_WR2:   state_d = S_WR3;
            S_WR3:   state_d = S_WR4;
            S_WR4: begin
                if (HOLD_BURST != 4'd0) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = HOLD_BURST;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q <= 4'd1) state_d = S_IDLE;
                else                    hold_cnt_d = hold_cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        abus_d = 2'b10;
        dbus_d = 8'h00;
        case (state_d)
            S_UNL_A, S_GAP: begin abus_d = 2'b00; dbus_d = 8'hAA; end
            S_UNL_B:        begin abus_d = 2'b00; dbus_d = 8'h55; end
            S_WR1: begin
                abus_d = is_cfg_q ? 2'b00 : 2'b10;
                dbus_d = is_cfg_q ? frame_q : cmd_q;
            end
            S_WR2: if (is_cfg_q) begin abus_d = 2'b01; dbus_d = service_q; end
            S_WR3: if (is_cfg_q) begin abus_d = 2'b11; dbus_d = limit_q; end
            default: ;
        endcase

        busy    = (state_q != S_IDLE) && (state_q != S_HOLD);
        cfg_ack = (state_q == S_WR4) && is_cfg_q;
        cmd_ack = (state_q == S_WR4) && !is_cfg_q;
        cmd_nak = nak_q;

        // A fail report in the same cycle as the config ack keeps the lock set.
        if (wd_fail)      fail_lock_d = 1'b1;
        else if (cfg_ack) fail_lock_d = 1'b0;
        else              fail_lock_d = fail_lock_q;
    end

    assign ABUS = abus_q;
    assign DBUS = dbus_q;

endmodule

// File: tb/tb_wd_bus_sequencer.sv
// Bench for wd_bus_sequencer: two instances (gap 0 / idle 1 and gap 2 / idle 3)
// driven by directed scenarios and random bursts against a burst-level model.
module tb_wd_bus_sequencer;

    logic       CLK = 1'b0;
    logic       rst         [2];
    logic       cfg_req     [2];
    logic [7:0] cfg_frame   [2];
    logic [7:0] cfg_service [2];
    logic [7:0] cfg_limit   [2];
    logic       cmd_req     [2];
    logic [7:0] cmd_data    [2];
    logic       wd_fail     [2];
    logic [1:0] abus        [2];
    logic [7:0] dbus        [2];
    logic       busy        [2];
    logic       cfg_ack     [2];
    logic       cmd_ack     [2];
    logic       cmd_nak     [2];

    bit lock        [2];
    bit cfg_ack_exp [2];
    int n_checks;
    int n_fail;

    localparam logic [13:0] IDLE_W = {2'b10, 8'h00, 4'b0000};

    always #5 CLK = ~CLK;

    wd_bus_sequencer #(.UNLOCK_GAP(0), .IDLE_MIN(1)) u_a (
        .CLK(CLK), .RST(rst[0]),
        .cfg_req(cfg_req[0]), .cfg_frame(cfg_frame[0]), .cfg_service(cfg_service[0]),
        .cfg_limit(cfg_limit[0]), .cmd_req(cmd_req[0]), .cmd_data(cmd_data[0]),
        .wd_fail(wd_fail[0]), .ABUS(abus[0]), .DBUS(dbus[0]), .busy(busy[0]),
        .cfg_ack(cfg_ack[0]), .cmd_ack(cmd_ack[0]), .cmd_nak(cmd_nak[0])
    );

    wd_bus_sequencer #(.UNLOCK_GAP(2), .IDLE_MIN(3)) u_b (
        .CLK(CLK), .RST(rst[1]),
        .cfg_req(cfg_req[1]), .cfg_frame(cfg_frame[1]), .cfg_service(cfg_service[1]),
        .cfg_limit(cfg_limit[1]), .cmd_req(cmd_req[1]), .cmd_data(cmd_data[1]),
        .wd_fail(wd_fail[1]), .ABUS(abus[1]), .DBUS(dbus[1]), .busy(busy[1]),
        .cfg_ack(cfg_ack[1]), .cmd_ack(cmd_ack[1]), .cmd_nak(cmd_nak[1])
    );

    function automatic int gap_of(input int idx);
        return (idx == 0) ? 0 : 2;
    endfunction

    function automatic int imin_of(input int idx);
        return (idx == 0) ? 1 : 3;
    endfunction

    function automatic logic [13:0] observed(input int idx);
        return {abus[idx], dbus[idx], busy[idx], cfg_ack[idx], cmd_ack[idx], cmd_nak[idx]};
    endfunction

    // Expected bus word for cycle c (0 = first AA cycle) of a burst.
    function automatic logic [13:0] slot_word(input int g, input int c, input bit is_cfg,
                                              input logic [7:0] d0, input logic [7:0] d1,
                                              input logic [7:0] d2);
        logic [1:0] a;
        logic [7:0] d;
        int         w;
        bit         last;
        last = (c == g + 5);
        w    = c - (g + 2);
        if (c <= g) begin
            a = 2'b00; d = 8'hAA;
        end else if (c == g + 1) begin
            a = 2'b00; d = 8'h55;
        end else if (is_cfg) begin
            case (w)
                0:       begin a = 2'b00; d = d0; end
                1:       begin a = 2'b01; d = d1; end
                2:       begin a = 2'b11; d = d2; end
                default: begin a = 2'b10; d = 8'h00; end
            endcase
        end else begin
            a = 2'b10;
            d = (w == 0) ? d0 : 8'h00;
        end
        return {a, d, 1'b1, is_cfg && last, !is_cfg && last, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed ABUS=%b DBUS=%h flags=%b expected ABUS=%b DBUS=%h flags=%b",
                   tag, obs[13:12], obs[11:4], obs[3:0], exp[13:12], exp[11:4], exp[3:0]);
        end
    endtask

    // Advance one clock; the fail-lock model follows the inputs seen at this edge.
    task automatic step();
        for (int i = 0; i < 2; i++) begin
            if (rst[i])              lock[i] = 1'b0;
            else if (wd_fail[i])     lock[i] = 1'b1;
            else if (cfg_ack_exp[i]) lock[i] = 1'b0;
            cfg_ack_exp[i] = 1'b0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_cycles(input int idx, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check(tag, observed(idx), IDLE_W);
            step();
        end
    endtask

    // One burst. already=1: the grant edge has passed and AA is on the bus now.
    // abort_at>=0: pulse reset in that burst cycle and return one cycle after
    // reset falls, with the request still asserted.
    task automatic run_burst(input int idx, input bit is_cfg, input logic [7:0] d0,
                             input logic [7:0] d1, input logic [7:0] d2, input bit keep,
                             input bit already, input int abort_at, input string tag);
        int g;
        g = gap_of(idx);
        if (is_cfg) begin
            cfg_frame[idx] = d0; cfg_service[idx] = d1; cfg_limit[idx] = d2;
            cfg_req[idx] = 1'b1;
        end else begin
            cmd_data[idx] = d0;
            cmd_req[idx]  = 1'b1;
        end
        if (!already) step();
        for (int c = 0; c < g + 6; c++) begin
            check(tag, observed(idx), slot_word(g, c, is_cfg, d0, d1, d2));
            if (c == abort_at) begin
                rst[idx] = 1'b1;
                step();
                check({tag, "_rst"}, observed(idx), IDLE_W);
                rst[idx] = 1'b0;
                step();
                return;
            end
            if (c == g + 5) cfg_ack_exp[idx] = is_cfg;
            step();
        end
        if (!keep) begin
            if (is_cfg) cfg_req[idx] = 1'b0;
            else        cmd_req[idx] = 1'b0;
        end
    endtask

    task automatic run_nak(input int idx, input logic [7:0] d0, input string tag);
        cmd_data[idx] = d0;
        cmd_req[idx]  = 1'b1;
        step();
        check(tag, observed(idx), {2'b10, 8'h00, 4'b0001});
        step();
        cmd_req[idx] = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; cfg_req[i] = 1'b0; cmd_req[i] = 1'b0; wd_fail[i] = 1'b0;
            cfg_frame[i] = 8'h00; cfg_service[i] = 8'h00; cfg_limit[i] = 8'h00;
            cmd_data[i] = 8'h00; lock[i] = 1'b0; cfg_ack_exp[i] = 1'b0;
        end
        step();
        step();
        check("reset_a", observed(0), IDLE_W);
        check("reset_b", observed(1), IDLE_W);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        step();

        // Config 0A/03/04 without gap.
        run_burst(0, 1'b1, 8'h0A, 8'h03, 8'h04, 1'b0, 1'b0, -1, "cfg_basic");
        idle_cycles(0, imin_of(0), "cfg_basic_idle");

        // Command 08 with a two-cycle unlock gap; busy spans exactly 8 cycles.
        run_burst(1, 1'b0, 8'h08, 8'h00, 8'h00, 1'b0, 1'b0, -1, "cmd_gap2");
        idle_cycles(1, imin_of(1), "cmd_gap2_idle");

        // Simultaneous requests: config first, one idle cycle, then the command.
        cmd_data[0] = 8'h08;
        cmd_req[0]  = 1'b1;
        run_burst(0, 1'b1, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, -1, "tie_cfg");
        idle_cycles(0, 1, "tie_hold");
        run_burst(0, 1'b0, 8'h08, 8'h00, 8'h00, 1'b0, 1'b1, -1, "tie_cmd");
        idle_cycles(0, imin_of(0), "tie_cmd_idle");

        // Fail lock: nak, then a clean config burst unlocks commands again.
        wd_fail[0] = 1'b1;
        idle_cycles(0, 1, "fail_pulse");
        wd_fail[0] = 1'b0;
        run_nak(0, 8'h08, "nak");
        idle_cycles(0, imin_of(0), "nak_idle");
        run_burst(0, 1'b1, 8'h20, 8'h05, 8'h07, 1'b0, 1'b0, -1, "unlock_cfg");
        idle_cycles(0, imin_of(0), "unlock_idle");
        run_burst(0, 1'b0, 8'h08, 8'h00, 8'h00, 1'b0, 1'b0, -1, "unlocked_cmd");
        idle_cycles(0, imin_of(0), "unlocked_idle");

        // Reset during WR2 drops the burst; the held request restarts it.
        run_burst(0, 1'b1, 8'h44, 8'h55, 8'h66, 1'b0, 1'b0, 3, "rst_burst");
        run_burst(0, 1'b1, 8'h44, 8'h55, 8'h66, 1'b0, 1'b1, -1, "rst_restart");
        idle_cycles(0, imin_of(0), "rst_restart_idle");

        // Request held through ack: next AA exactly IDLE_MIN+1 cycles after ack.
        run_burst(1, 1'b1, 8'h9C, 8'h3E, 8'hF1, 1'b1, 1'b0, -1, "keep_first");
        idle_cycles(1, imin_of(1), "keep_gap");
        run_burst(1, 1'b1, 8'h9C, 8'h3E, 8'hF1, 1'b0, 1'b1, -1, "keep_second");
        idle_cycles(1, imin_of(1), "keep_idle");

        // Random traffic on both instances, outcome chosen by the lock model.
        for (int n = 0; n < 24; n++) begin
            int         idx;
            bit         is_cfg;
            logic [7:0] d0, d1, d2;
            idx    = int'($urandom_range(0, 1));
            is_cfg = bit'($urandom_range(0, 1));
            d0     = 8'($urandom);
            d1     = 8'($urandom);
            d2     = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                wd_fail[idx] = 1'b1;
                idle_cycles(idx, 1, "rnd_fail");
                wd_fail[idx] = 1'b0;
            end
            if (!is_cfg && lock[idx]) run_nak(idx, d0, "rnd_nak");
            else run_burst(idx, is_cfg, d0, d1, d2, 1'b0, 1'b0, -1, "rnd_burst");
            idle_cycles(idx, imin_of(idx), "rnd_idle");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
